// File: rtl/sfifo_watermark_if.sv
// sfifo_watermark_if: push/pop bus of the watermark FIFO.
// The master side is the producer/consumer; the slave side is the FIFO.
interface sfifo_watermark_if #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
);
  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              o_full;
  logic [LGFLEN:0]   o_fill;
  logic              i_rd;
  logic [BW-1:0]     o_data;
  logic              o_empty;

  modport master (
    output i_wr, i_data, i_rd,
    input  o_full, o_fill, o_data, o_empty
  );

  modport slave (
    input  i_wr, i_data, i_rd,
    output o_full, o_fill, o_data, o_empty
  );
endinterface

// File: rtl/sfifo_watermark.sv
// sfifo_watermark: synchronous FIFO with hysteretic watermark flag,
// rising-edge interrupt and sticky overflow/underflow errors.
module sfifo_watermark #(
  parameter int BW             = 8,
  parameter int LGFLEN         = 4,
  parameter bit OPT_ASYNC_READ = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  sfifo_watermark_if.slave bus,
  input  logic [LGFLEN:0] i_hi_thresh,
  input  logic [LGFLEN:0] i_lo_thresh,
  output logic            o_hi,
  output logic            o_lo,
  output logic            o_level,
  output logic            o_int,
  input  logic            i_err_clr,
  output logic            o_overflow,
  output logic            o_underflow
);

  localparam int FLEN = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULLV =
    (LGFLEN+1)'(FLEN);
  localparam logic [LGFLEN:0] FONE = 1;
  localparam logic [LGFLEN-1:0] PONE = 1;

  typedef enum logic {
    LVL_LOW  = 1'b0,
    LVL_HIGH = 1'b1
  } lvl_e;

  logic [BW-1:0]     mem_q [FLEN];
  logic [LGFLEN-1:0] wr_ptr_q;
  logic [LGFLEN-1:0] rd_ptr_q;
  logic [LGFLEN-1:0] rd_nxt;
  logic [LGFLEN:0]   fill_q;
  logic [LGFLEN:0]   fill_d;
  logic              full_q;
  logic              empty_q;
  logic              hi_q;
  logic              lo_q;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;
  lvl_e              state_q;
  lvl_e              state_d;
  logic              int_q;
  logic              int_d;
  logic              w_wr;
  logic              w_rd;

  // Nothing is accepted during the reset cycle.
  assign w_wr = bus.i_wr && !full_q && !i_reset;
  assign w_rd = bus.i_rd && !empty_q && !i_reset;
  assign rd_nxt = rd_ptr_q + PONE;

  // Next fill level drives counters, flags and the level FSM.
  always_comb begin
    fill_d = fill_q;
    unique case (1'b1)
      (w_wr && !w_rd): fill_d = fill_q + FONE;
      (!w_wr && w_rd): fill_d = fill_q - FONE;
      default:         fill_d = fill_q;
    endcase
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= bus.i_data;
  end

  // Pointers, fill count and the watermark compares.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      hi_q     <= 1'b0;
      lo_q     <= 1'b1;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + PONE;
      if (w_rd) rd_ptr_q <= rd_nxt;
      fill_q  <= fill_d;
      full_q  <= (fill_d == FULLV);
      empty_q <= (fill_d == '0);
      hi_q    <= (fill_d >= i_hi_thresh);
      lo_q    <= (fill_d <= i_lo_thresh);
    end
  end

  // Sticky errors: a new error beats a clear.
  always_comb begin
    ovf_d = (bus.i_wr && full_q) ||
            (ovf_q && !i_err_clr);
    unf_d = (bus.i_rd && empty_q) ||
            (unf_q && !i_err_clr);
  end

  // Sticky error registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Level FSM state and its registered entry pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= LVL_LOW;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
    end
  end

  // Only the exit condition of the current state is tested.
  always_comb begin
    state_d = state_q;
    int_d   = 1'b0;
    unique case (state_q)
      LVL_LOW: begin
        if (fill_d >= i_hi_thresh) begin
          state_d = LVL_HIGH;
          int_d   = 1'b1;
        end
      end
      LVL_HIGH: begin
        if (fill_d <= i_lo_thresh)
          state_d = LVL_LOW;
      end
      default: state_d = LVL_LOW;
    endcase
  end

  // Level FSM outputs.
  always_comb begin
    o_level = (state_q == LVL_HIGH);
    o_int   = int_q;
  end

  assign bus.o_full    = full_q;
  assign bus.o_empty   = empty_q;
  assign bus.o_fill    = fill_q;
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;

  if (OPT_ASYNC_READ) begin : g_async
    assign bus.o_data = mem_q[rd_ptr_q];
  end else begin : g_sync
    logic [BW-1:0] rdata_q;

    // Head register: reload on pop, bypass when the
    // written word becomes the head next cycle.
    always_ff @(posedge i_clk) begin
      if (w_rd) begin
        if (w_wr && (wr_ptr_q == rd_nxt))
          rdata_q <= bus.i_data;
        else
          rdata_q <= mem_q[rd_nxt];
      end else if (w_wr && empty_q) begin
        rdata_q <= bus.i_data;
      end
    end

    assign bus.o_data = rdata_q;
  end

endmodule
